// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one ALU between two requesters: latches the
// winner's operation, waits ALU_LAT cycles, captures the result and pulses res_en.
module alu_req_sched #(
    parameter int DW      = 4,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           req1_ready,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW:0]    alu_res,
    output logic           res_en,
    output logic [DW:0]    res_data,
    output logic           res_owner,
    output logic           busy
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WRITE
    } stateType;

    stateType       state;
    stateType       nextState;
    logic [CW-1:0]  cnt;
    logic           lastGrant;
    logic           winner;
    logic           grant0;
    logic           grant1;
    logic           handshake;
    logic           capture;

    // Winner is the sole valid requester, or the one not served last time.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~lastGrant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
        grant0 = (state == IDLE) && req0_valid && !winner;
        grant1 = (state == IDLE) && req1_valid && winner;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign handshake  = grant0 | grant1;
    assign capture    = (state == EXEC) && (cnt == CW'(1));

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (handshake) nextState = EXEC;
            EXEC:    if (capture)   nextState = WRITE;
            WRITE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign res_en = (state == WRITE);
    assign busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lastGrant <= 1'b1;
            cnt       <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_data  <= '0;
            res_owner <= 1'b0;
        end else if (handshake) begin
            alu_op    <= winner ? req1_op : req0_op;
            alu_a     <= winner ? req1_a  : req0_a;
            alu_b     <= winner ? req1_b  : req0_b;
            lastGrant <= winner;
            res_owner <= winner;
            cnt       <= CW'(ALU_LAT);
        end else if (state == EXEC) begin
            cnt <= cnt - CW'(1);
            // alu_res passes through untouched, overflow bit included.
            if (capture) begin
                res_data <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each fed by a combinational 4-bit adder stub.
module tb_alu_req_sched;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;

    logic       r0v, r1v;
    logic [2:0] r0op, r1op;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic       r0rdy, r1rdy;
    logic [2:0] aluOp;
    logic [3:0] aluA, aluB;
    logic [4:0] aluRes;
    logic       resEn, resOwner, busy;
    logic [4:0] resData;

    logic       bR0v;
    logic [2:0] bR0op;
    logic [3:0] bR0a, bR0b;
    logic       bR0rdy, bR1rdy;
    logic [2:0] bAluOp;
    logic [3:0] bAluA, bAluB;
    logic [4:0] bAluRes;
    logic       bResEn, bResOwner, bBusy;
    logic [4:0] bResData;
    logic       bZero = 1'b0;
    logic [2:0] bZeroOp = 3'd0;
    logic [3:0] bZeroD = 4'd0;

    int testCnt = 0;
    int failCnt = 0;

    always #5 Clk = ~Clk;

    assign aluRes  = {1'b0, aluA} + {1'b0, aluB};
    assign bAluRes = {1'b0, bAluA} + {1'b0, bAluB};

    alu_req_sched #(.DW(4), .OPW(3), .ALU_LAT(1)) dutA (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(r0v), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0rdy),
        .req1_valid(r1v), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1rdy),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_res(aluRes),
        .res_en(resEn), .res_data(resData), .res_owner(resOwner), .busy(busy)
    );

    alu_req_sched #(.DW(4), .OPW(3), .ALU_LAT(3)) dutB (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(bR0v), .req0_op(bR0op), .req0_a(bR0a), .req0_b(bR0b), .req0_ready(bR0rdy),
        .req1_valid(bZero), .req1_op(bZeroOp), .req1_a(bZeroD), .req1_b(bZeroD), .req1_ready(bR1rdy),
        .alu_op(bAluOp), .alu_a(bAluA), .alu_b(bAluB), .alu_res(bAluRes),
        .res_en(bResEn), .res_data(bResData), .res_owner(bResOwner), .busy(bBusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hsCyc[4];
        int hsOwn[4];
        int nHs;
        logic sawAct;

        r0v = 0; r1v = 0; r0op = 0; r1op = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        bR0v = 0; bR0op = 0; bR0a = 0; bR0b = 0;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_res_en", resEn, 0);
        check("rst_alu_a", aluA, 0);
        check("rst_res_data", resData, 0);
        check("rst_res_owner", resOwner, 0);
        tick();
        Rst = 1'b1;

        // Basic add by requester 0: 5+3
        r0v = 1; r0op = 3'd0; r0a = 4'd5; r0b = 4'd3;
        @(negedge Clk);
        check("t1_ready0", r0rdy, 1);
        check("t1_ready1", r1rdy, 0);
        tick();
        r0v = 0;
        @(negedge Clk);
        check("t1_busy", busy, 1);
        check("t1_alu_a", aluA, 5);
        check("t1_alu_b", aluB, 3);
        check("t1_en_early", resEn, 0);
        tick();
        @(negedge Clk);
        check("t1_res_en", resEn, 1);
        check("t1_res_data", resData, 5'b0_1000);
        check("t1_owner", resOwner, 0);
        tick();
        @(negedge Clk);
        check("t1_idle", busy, 0);
        check("t1_en_off", resEn, 0);
        check("t1_hold", resData, 5'b0_1000);
        tick();

        // Overflow by requester 1: 9+9
        r1v = 1; r1op = 3'd0; r1a = 4'd9; r1b = 4'd9;
        @(negedge Clk);
        check("ov_ready1", r1rdy, 1);
        check("ov_ready0", r0rdy, 0);
        tick();
        r1v = 0;
        tick();
        @(negedge Clk);
        check("ov_res_en", resEn, 1);
        check("ov_res_data", resData, 5'b1_0010);
        check("ov_owner", resOwner, 1);
        tick();

        // Withdrawn request: req0 valid only while busy
        r1v = 1; r1a = 4'd1; r1b = 4'd1;
        @(negedge Clk);
        check("wd_ready1", r1rdy, 1);
        tick();
        r1v = 0; r0v = 1; r0a = 4'd4; r0b = 4'd4;
        @(negedge Clk);
        check("wd_ready0_exec", r0rdy, 0);
        tick();
        r0v = 0;
        @(negedge Clk);
        check("wd_ready0_write", r0rdy, 0);
        check("wd_res_data", resData, 5'd2);
        tick();
        @(negedge Clk);
        check("wd_idle1", busy, 0);
        tick();
        @(negedge Clk);
        check("wd_idle2", busy, 0);
        check("wd_no_en", resEn, 0);
        check("wd_data_kept", resData, 5'd2);
        tick();

        // Round robin from reset with both requesters valid continuously
        Rst = 0;
        tick();
        Rst = 1;
        r0v = 1; r0a = 4'd1; r0b = 4'd2;
        r1v = 1; r1a = 4'd15; r1b = 4'd1;
        nHs = 0;
        for (int i = 0; i < 4; i++) begin
            hsCyc[i] = -1;
            hsOwn[i] = -1;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            check("rr_onehot", r0rdy & r1rdy, 0);
            if ((r0rdy | r1rdy) && nHs < 4) begin
                hsCyc[nHs] = c;
                hsOwn[nHs] = int'(r1rdy);
                nHs++;
            end
            if (c == 2 || c == 5) begin
                check("rr_res_en", resEn, 1);
                check("rr_res_data", resData, (c == 2) ? 32'd3 : 32'd16);
            end
            tick();
        end
        r0v = 0; r1v = 0;
        for (int i = 0; i < 4; i++) begin
            check("rr_hs_cycle", hsCyc[i], 3 * i);
            check("rr_hs_owner", hsOwn[i], i % 2);
        end
        tick();
        tick();

        // Asynchronous reset during EXEC
        r0v = 1; r0a = 4'd2; r0b = 4'd2;
        @(negedge Clk);
        check("ar_ready0", r0rdy, 1);
        tick();
        r0v = 0;
        #2;
        Rst = 0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_res_en", resEn, 0);
        check("ar_alu_a", aluA, 0);
        check("ar_alu_b", aluB, 0);
        check("ar_res_data", resData, 0);
        check("ar_owner", resOwner, 0);
        tick();
        tick();
        Rst = 1;
        sawAct = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            sawAct = sawAct | resEn | busy;
            tick();
        end
        check("ar_no_follow", sawAct, 0);
        r0v = 1; r0a = 4'd2; r0b = 4'd7;
        @(negedge Clk);
        check("ar_ready_after", r0rdy, 1);
        tick();
        r0v = 0;
        tick();
        @(negedge Clk);
        check("ar_res_en_after", resEn, 1);
        check("ar_data_after", resData, 5'd9);
        tick();

        // ALU_LAT=3 instance
        bR0v = 1; bR0op = 3'd5; bR0a = 4'd6; bR0b = 4'd7;
        @(negedge Clk);
        check("l3_ready", bR0rdy, 1);
        tick();
        bR0v = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clk);
            check("l3_busy", bBusy, 1);
            check("l3_op", bAluOp, 5);
            check("l3_a", bAluA, 6);
            check("l3_b", bAluB, 7);
            check("l3_no_en", bResEn, 0);
            tick();
        end
        @(negedge Clk);
        check("l3_res_en", bResEn, 1);
        check("l3_busy_write", bBusy, 1);
        check("l3_res_data", bResData, 5'd13);
        check("l3_owner", bResOwner, 0);
        tick();
        @(negedge Clk);
        check("l3_idle", bBusy, 0);
        check("l3_en_off", bResEn, 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
